apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB3 requester that turns a simple valid/ready command stream into APB SETUP/ACCESS transfers and returns a registered response. It sits directly upstream of the APB memory slave, drives its PSELx/PENABLE/PWRITE/PADDR/PWDATA, and consumes PRDATA/PREADY/PSLVERR. Its wait-state handling is built for slaves that insert one or more wait cycles, including the one-wait-state memory slave.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, ACCESS wait cycles before abort (used only with APB_MASTER_TIMEOUT_EN; legal 1..255)

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  transfer address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data; 0 for writes and aborts
- rsp_err  out  1  PSLVERR captured, or timeout abort
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE:
  - req_ready = 1.
  - On accept, latch req_write/req_addr/req_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP:
  - PSELx = 1, PENABLE = 0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSELx = 1, PENABLE = 1.
  - If PREADY = 0, stay.
  - If PREADY = 1:
    - capture PRDATA into rsp_rdata on reads (0 on writes);
    - capture PSLVERR into rsp_err;
    - drop PSELx and PENABLE;
    - go to RESP.
- RESP:
  - rsp_valid = 1.
  - When rsp_ready = 1, go to IDLE.
  - rsp_rdata/rsp_err hold stable until the handshake.
- PWRITE/PADDR/PWDATA:
  - stable from SETUP through the end of ACCESS;
  - retain last values in IDLE and RESP.
- req_ready = 0 in SETUP, ACCESS and RESP. Exactly one transfer is in flight.
- Reset values: PSELx, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err = 0; req_ready = 1 (state IDLE).
- Reset mid-transfer: returns to IDLE immediately and asynchronously. The in-flight transfer is dropped and no response is produced.

## Timing
- Cycle 0 is the accept edge.
- SETUP is visible in cycle 1 and ACCESS from cycle 2.
- With a zero-wait slave:
  - PREADY = 1 in cycle 2;
  - rsp_valid = 1 in cycle 3;
  - IDLE at the earliest in cycle 4.
- With the one-wait-state memory slave:
  - PREADY = 1 in cycle 3;
  - PRDATA is valid in the same cycle;
  - rsp_valid = 1 in cycle 4.
- Each wait state adds one cycle.
- rsp_ready held low stalls in RESP indefinitely. No new APB transfer starts.
- PREADY and PSLVERR are ignored outside ACCESS.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - an 8-bit wait counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0;
  - when the counter equals TIMEOUT_CYCLES while PREADY = 0, the block aborts: PSELx = 0, PENABLE = 0, rsp_rdata = 0, rsp_err = 1, go to RESP;
  - PREADY = 1 in the same cycle as the limit wins, giving a normal completion.
- APB_MASTER_TIMEOUT_EN undefined: no counter exists, and ACCESS waits for PREADY forever.

## Structure
- Shared package apb_pkg holds:
  - apb_state_e (IDLE, SETUP, ACCESS, RESP);
  - APB_ADDR_W and APB_DATA_W default constants (32);
  - the apb_req_t struct (write, addr, wdata);
  - the apb_rsp_t struct (rdata, err).
- One sub-module, apb_wait_timer (counter, clear, increment, expired flag), instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write then read with the memory slave:
  - write addr 0x10, data 0xDEADBEEF, then read 0x10;
  - write response: rsp_err = 0, rsp_rdata = 0;
  - read response: rsp_rdata = 0xDEADBEEF, rsp_valid in cycle 4 after accept;
  - PSELx high in cycles 1–3, PENABLE high in cycles 2–3.
- Back-to-back commands with req_valid held high:
  - second accept only after the first rsp handshake;
  - PADDR never changes while PSELx = 1.
- Response backpressure:
  - hold rsp_ready = 0 for 10 cycles after a read of 0x20 returning 0x12345678;
  - rsp_valid and rsp_rdata stay stable;
  - req_ready stays 0 and PSELx stays 0.
- PSLVERR forced to 1 with PREADY on a read of 0x30 → rsp_err = 1.
- Timeout with the macro defined, TIMEOUT_CYCLES = 16, PREADY tied 0:
  - 16 ACCESS cycles, then PSELx = 0;
  - rsp_err = 1, rsp_rdata = 0.
  - Without the macro, PSELx and PENABLE stay high indefinitely.
- PRESETn pulsed low during ACCESS:
  - all outputs return to 0 immediately and req_ready = 1;
  - no response is produced;
  - the next read works normally after reset release.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and defaults for the APB requester slice.
// FSM encoding plus request/response bundles.
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_if.sv
// apb_master_if: command stream, response stream and APB bus signals.
// master modport is the requester side, slave modport its environment.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        input  rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        output rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: 8-bit ACCESS wait-state counter with expiry flag.
module apb_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);
    // Expired means the current waiting cycle is the LIMIT-th one.
    localparam logic [7:0] LP_LAST = 8'(LIMIT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 requester with registered response.
// ACCESS timeout abort is built only when APB_MASTER_TIMEOUT_EN is defined.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          PCLK,
    input logic          PRESETn,
    apb_master_if.master bus
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
        $error("apb_master: TIMEOUT_CYCLES must be 1..255");
    end

    apb_state_e        r_state, w_state;
    logic              r_req_ready, w_req_ready;
    logic              r_psel, w_psel;
    logic              r_penable, w_penable;
    logic              r_pwrite, w_pwrite;
    logic [ADDR_W-1:0] r_paddr, w_paddr;
    logic [DATA_W-1:0] r_pwdata, w_pwdata;
    logic              r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
    logic              r_rsp_err, w_rsp_err;
    logic              w_expired;

`ifdef APB_MASTER_TIMEOUT_EN
    logic w_tmr_clr;
    logic w_tmr_inc;

    assign w_tmr_clr = (r_state == SETUP);
    assign w_tmr_inc = (r_state == ACCESS) && !bus.PREADY;

    apb_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .i_clk    (PCLK),
        .i_rst_n  (PRESETn),
        .i_clear  (w_tmr_clr),
        .i_inc    (w_tmr_inc),
        .o_expired(w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_req_ready <= w_req_ready;
            r_psel      <= w_psel;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_rsp_err;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_req_ready = r_req_ready;
        w_psel      = r_psel;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_rsp_valid = r_rsp_valid;
        w_rsp_rdata = r_rsp_rdata;
        w_rsp_err   = r_rsp_err;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_state     = SETUP;
                    w_req_ready = 1'b0;
                    w_psel      = 1'b1;
                    w_penable   = 1'b0;
                    w_pwrite    = bus.req_write;
                    w_paddr     = bus.req_addr;
                    w_pwdata    = bus.req_wdata;
                end
            end
            SETUP: begin
                w_state   = ACCESS;
                w_penable = 1'b1;
            end
            ACCESS: begin
                if (bus.PREADY) begin
                    w_state     = RESP;
                    w_psel      = 1'b0;
                    w_penable   = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = r_pwrite ? '0 : bus.PRDATA;
                    w_rsp_err   = bus.PSLVERR;
                end else if (w_expired) begin
                    w_state     = RESP;
                    w_psel      = 1'b0;
                    w_penable   = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_rdata = '0;
                    w_rsp_err   = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_state     = IDLE;
                    w_rsp_valid = 1'b0;
                    w_req_ready = 1'b1;
                end
            end
        endcase
    end

    assign bus.req_ready = r_req_ready;
    assign bus.PSELx     = r_psel;
    assign bus.PENABLE   = r_penable;
    assign bus.PWRITE    = r_pwrite;
    assign bus.PADDR     = r_paddr;
    assign bus.PWDATA    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: random command stream against a wait-state memory slave.
// Responses and bus phases are checked against a transaction-level model.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TMO = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int HANG_RST = 0;
`else
    localparam int HANG_RST = 40;
`endif

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .PCLK   (clk),
        .PRESETn(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory slave with a programmable number of wait states.
    int             cfg_waits;
    bit             cfg_err;
    int             wcnt;
    bit [31:0]      mem     [bit [31:0]];
    bit [31:0]      ref_mem [bit [31:0]];

    always @(posedge clk) begin
        if (bus.PSELx && bus.PENABLE && bus.PREADY && bus.PWRITE && !bus.PSLVERR)
            mem[bus.PADDR] = bus.PWDATA;
        #1;
        if (bus.PSELx && bus.PENABLE) begin
            if (wcnt == cfg_waits) begin
                bus.PREADY  = 1'b1;
                bus.PSLVERR = cfg_err;
                bus.PRDATA  = bus.PWRITE ? $urandom : mem[bus.PADDR];
            end else begin
                bus.PREADY  = 1'b0;
                bus.PSLVERR = 1'($urandom);
                bus.PRDATA  = $urandom;
            end
            wcnt++;
        end else begin
            wcnt        = 0;
            bus.PREADY  = 1'($urandom);
            bus.PSLVERR = 1'($urandom);
            bus.PRDATA  = $urandom;
        end
    end

    function automatic bit [31:0] ref_rd(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    // One command from accept through response handshake (or reset).
    task automatic xfer(input bit w, input bit [31:0] a, input bit [31:0] d,
                        input int waits, input bit serr, input int rdly,
                        input int rst_at, input bit keep);
        apb_rsp_t exp;
        bit       abort;
        bit       e_sel;
        bit       e_en;
        bit       e_rv;
        int       lat;
        int       k;
        abort = 1'b0;
        lat   = waits;
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits >= TMO) begin
            abort = 1'b1;
            lat   = TMO - 1;
        end
`endif
        exp.err   = abort | serr;
        exp.rdata = (w || abort) ? 32'h0 : ref_rd(a);
        cfg_waits = waits;
        cfg_err   = serr;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        k = 0;
        while (bus.req_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("accept_rdy", 64'(bus.req_ready), 64'(1));
        @(posedge clk);
        for (k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (k == 1 && !keep) begin
                bus.req_valid = 1'b0;
                bus.req_write = 1'($urandom);
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
            end
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_ctl", 64'({bus.PSELx, bus.PENABLE, bus.PWRITE,
                    bus.rsp_valid, bus.rsp_err, bus.req_ready}), 64'(6'b000001));
                chk("rst_bus", {bus.PADDR, bus.PWDATA}, 64'(0));
                chk("rst_rdata", 64'(bus.rsp_rdata), 64'(0));
                bus.req_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("rst_norsp", 64'({bus.rsp_valid, bus.PSELx, bus.req_ready}),
                        64'(3'b001));
                end
                return;
            end
            e_sel = (k <= lat + 2);
            e_en  = (k >= 2) && (k <= lat + 2);
            e_rv  = (k >= lat + 3);
            chk("phase", 64'({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.req_ready}),
                64'({e_sel, e_en, e_rv, 1'b0}));
            if (bus.PSELx) begin
                chk("paddr", 64'(bus.PADDR), 64'(a));
                chk("pwrite", 64'(bus.PWRITE), 64'(w));
                if (w) chk("pwdata", 64'(bus.PWDATA), 64'(d));
            end
        end
        for (int j = 0; j <= rdly; j++) begin
            if (j > 0) begin
                @(negedge clk);
                chk("hold", 64'({bus.rsp_valid, bus.req_ready, bus.PSELx}), 64'(3'b100));
            end
            chk("rdata", 64'(bus.rsp_rdata), 64'(exp.rdata));
            chk("rerr", 64'(bus.rsp_err), 64'(exp.err));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("post", 64'({bus.rsp_valid, bus.req_ready, bus.PSELx, bus.PENABLE}),
            64'(4'b0100));
        if (w && !serr && !abort) ref_mem[a] = d;
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        cfg_waits     = 0;
        cfg_err       = 1'b0;
        wcnt          = 0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.PREADY    = 1'b0;
        bus.PSLVERR   = 1'b0;
        bus.PRDATA    = '0;
        repeat (2) @(negedge clk);
        chk("reset_ctl", 64'({bus.PSELx, bus.PENABLE, bus.PWRITE,
            bus.rsp_valid, bus.rsp_err, bus.req_ready}), 64'(6'b000001));
        chk("reset_bus", {bus.PADDR, bus.PWDATA}, 64'(0));
        chk("reset_rdata", 64'(bus.rsp_rdata), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back through the one-wait-state slave.
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 1, 1'b0, 0, 0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0, 1, 1'b0, 0, 0, 1'b0);

        // Back-to-back with req_valid held high.
        for (int i = 0; i < 4; i++)
            xfer(1'($urandom), 32'(i) << 2, $urandom, $urandom_range(0, 3),
                 1'b0, 0, 0, 1'b1);
        bus.req_valid = 1'b0;

        // Response backpressure.
        xfer(1'b1, 32'h20, 32'h12345678, 1, 1'b0, 0, 0, 1'b0);
        xfer(1'b0, 32'h20, 32'h0, 1, 1'b0, 10, 0, 1'b1);
        bus.req_valid = 1'b0;

        // Slave error on read and on write.
        xfer(1'b0, 32'h30, 32'h0, 0, 1'b1, 0, 0, 1'b0);
        xfer(1'b1, 32'h10, 32'hBAD0BAD0, 2, 1'b1, 0, 0, 1'b0);
        xfer(1'b0, 32'h10, 32'h0, 0, 1'b0, 0, 0, 1'b0);

        // Reset during ACCESS, then a normal read.
        xfer(1'b1, 32'h10, 32'h55AA55AA, 5, 1'b0, 0, 3, 1'b0);
        xfer(1'b0, 32'h10, 32'h0, 1, 1'b0, 0, 0, 1'b0);

        // Slave that never answers: abort or indefinite wait.
        xfer(1'b0, 32'h40, 32'h0, 1000, 1'b0, 0, HANG_RST, 1'b0);
        xfer(1'b0, 32'h20, 32'h0, 0, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++)
            xfer(1'($urandom), 32'($urandom_range(0, 7)) << 2, $urandom,
                 $urandom_range(0, 4), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 3), 0, 1'($urandom));
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
